// File: rtl/fwd_ctrl_scoreboard_if.sv
// rtl/fwd_ctrl_scoreboard_if.sv - decode/forwarding signal bundle for the forwarding scoreboard
interface fwd_ctrl_scoreboard_if #(
    parameter int CNT_W = 16
);
    logic             dec_valid;
    logic [3:0]       dec_srcA;
    logic [3:0]       dec_srcB;
    logic [3:0]       dec_dstE;
    logic [3:0]       dec_dstM;
    logic             ex2_cnd;
    logic             flush;
    logic             mem_wait;
    logic             dec_stall;
    logic             applyEx2Fwd;
    logic [1:0]       applyMemFwd;
    logic [3:0]       ex2_regA;
    logic [3:0]       mem_regA;
    logic [3:0]       mem_regB;
    logic [CNT_W-1:0] stall_count;

    // Pipeline side: drives decode/control, observes stall and forwarding selects
    modport master (
        output dec_valid, dec_srcA, dec_srcB, dec_dstE, dec_dstM,
        output ex2_cnd, flush, mem_wait,
        input  dec_stall, applyEx2Fwd, applyMemFwd, ex2_regA, mem_regA, mem_regB,
        input  stall_count
    );

    // Scoreboard side
    modport slave (
        input  dec_valid, dec_srcA, dec_srcB, dec_dstE, dec_dstM,
        input  ex2_cnd, flush, mem_wait,
        output dec_stall, applyEx2Fwd, applyMemFwd, ex2_regA, mem_regA, mem_regB,
        output stall_count
    );
endinterface

// File: rtl/fwd_ctrl_scoreboard.sv
// rtl/fwd_ctrl_scoreboard.sv - destination-register scoreboard driving the E-stage forwarding mux
module fwd_ctrl_scoreboard #(
    parameter logic [3:0] RNONE = 4'hF,
    parameter int          CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    fwd_ctrl_scoreboard_if.slave  bus
);
    // In-flight destinations per stage
    logic       eValid,   ex2Valid,   memValid;
    logic [3:0] eDstE,    ex2DstE,    memDstE;
    logic [3:0] eDstM,    ex2DstM,    memDstM;
    logic [CNT_W-1:0] stallCount;

    logic [3:0] ex2Eff;
    logic [3:0] memRegA;
    logic [3:0] memRegB;
    logic       luh;
    logic       takeStall;
    logic       insertBubble;

    // Effective destinations and load-use hazard detection
    always_comb begin
        ex2Eff  = (ex2Valid && bus.ex2_cnd) ? ex2DstE : RNONE;
        memRegA = memValid ? memDstE : RNONE;
        memRegB = memValid ? memDstM : RNONE;
        // Only a load sitting in E forces a bubble; ALU results and loads in E2
        // are reachable through the forwarding paths one cycle later.
        luh = bus.dec_valid && eValid && (eDstM != RNONE) &&
              ((bus.dec_srcA == eDstM) || (bus.dec_srcB == eDstM));
        takeStall    = luh && !bus.flush;
        insertBubble = bus.flush || luh || !bus.dec_valid;
    end

    assign bus.ex2_regA    = ex2Eff;
    assign bus.applyEx2Fwd = (ex2Eff != RNONE);
    assign bus.mem_regA    = memRegA;
    assign bus.mem_regB    = memRegB;
    assign bus.applyMemFwd = {memRegA != RNONE, memRegB != RNONE};
    assign bus.dec_stall   = bus.mem_wait || takeStall;
    assign bus.stall_count = stallCount;

    // Advance E -> E2 -> M unless memory holds the pipeline; squashed cmov dstE travels as RNONE
    always_ff @(posedge clk) begin
        if (reset) begin
            eValid     <= 1'b0;
            eDstE      <= RNONE;
            eDstM      <= RNONE;
            ex2Valid   <= 1'b0;
            ex2DstE    <= RNONE;
            ex2DstM    <= RNONE;
            memValid   <= 1'b0;
            memDstE    <= RNONE;
            memDstM    <= RNONE;
            stallCount <= '0;
        end else if (!bus.mem_wait) begin
            memValid <= ex2Valid;
            memDstE  <= ex2Eff;
            memDstM  <= ex2DstM;
            ex2Valid <= eValid;
            ex2DstE  <= eDstE;
            ex2DstM  <= eDstM;
            if (insertBubble) begin
                eValid <= 1'b0;
                eDstE  <= RNONE;
                eDstM  <= RNONE;
            end else begin
                eValid <= 1'b1;
                eDstE  <= bus.dec_dstE;
                eDstM  <= bus.dec_dstM;
            end
            if (takeStall && (stallCount != {CNT_W{1'b1}})) begin
                stallCount <= stallCount + 1'b1;
            end
        end
    end
endmodule
